ws2812_rx: RTL and testbench

- Single-wire WS2812 (NRZ, GRB) stream decoder: the receiving end of the LED strip driver's serial output.
- Measures high-pulse widths, reassembles 24-bit pixel words and detects the latch (reset) gap.
- Presents each pixel on an addr/data/wen write port for the frame buffer or checker.
- Used as a loop-back monitor on the strip line and as an in-system frame capture for debug.

---
 rtl/ws2812_pkg.sv | 27 ++
 rtl/ws2812_pulse_meas.sv | 63 ++++++
 rtl/ws2812_rx.sv | 163 ++++++++++++++++
 tb/tb_ws2812_rx.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// ws2812_pkg
// Timing constants and shared types for the WS2812 line. The strip
// driver and the receiver both use these values. The timing constants
// assume a 50 MHz clk.
//   BIT_THRESH   : a high pulse at least this many cycles long decodes as 1
//   MIN_HIGH     : high pulses shorter than this are treated as glitches
//   RESET_CYCLES : a low level at least this long is a latch gap
//   NUM_LEDS     : number of pixels in the strip (addresses 1..NUM_LEDS)
package ws2812_pkg;

    localparam int BIT_THRESH   = 30;
    localparam int MIN_HIGH     = 5;
    localparam int RESET_CYCLES = 2500;
    localparam int NUM_LEDS     = 60;

    localparam int WORD_W = 24;
    localparam int ADDR_W = 6;
    localparam int CNT_W  = 12;
    localparam int BCNT_W = 5;

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        LOW       = 2'd1,
        HIGH      = 2'd2
    } rx_state_t;

endpackage

// File: rtl/ws2812_pulse_meas.sv
// ws2812_pulse_meas
// Synchronises the raw strip line, detects edges and measures how long
// the current level has lasted.
//   clk, reset   : system clock, synchronous active-high reset
//   din          : asynchronous strip line
//   rise, fall   : one-cycle pulses on synchronised edges
//   width        : at a fall, the width of the high pulse that just ended;
//                  otherwise the cycles elapsed in the current level (saturating)
//   low_timeout  : line has been low for at least RESET_CYCLES
//   low_gap      : one-cycle pulse when the low level reaches RESET_CYCLES
//   high_timeout : line has been high for at least RESET_CYCLES
module ws2812_pulse_meas
    import ws2812_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] width,
    output logic             low_timeout,
    output logic             low_gap,
    output logic             high_timeout
);

    // The edge cycle itself counts as 1, so a steady level of duration d
    // reaches d-1 on its last cycle and a fall reads the full high width.
    localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(RESET_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic             prev;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            prev   <= 1'b0;
            cnt    <= '0;
        end else begin
            sync_1 <= din;
            sync_2 <= sync_1;
            prev   <= sync_2;
            if (sync_2 != prev) begin
                cnt <= CNT_W'(1);
            end else if (cnt != '1) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign rise  = sync_2 & ~prev;
    assign fall  = ~sync_2 & prev;
    assign width = cnt;

    // Qualified with prev so the stale count of the previous level is
    // never mistaken for a timeout on the edge cycle.
    assign low_timeout  = ~sync_2 & ~prev & (cnt >= TIMEOUT);
    assign low_gap      = ~sync_2 & ~prev & (cnt == TIMEOUT);
    assign high_timeout = sync_2 & prev & (cnt >= TIMEOUT);

endmodule

// File: rtl/ws2812_rx.sv
// ws2812_rx
// WS2812 (NRZ, GRB) stream decoder. Reassembles 24-bit pixel words from
// high-pulse widths and writes them out on an addr/data/wen port.
//   clk, reset : system clock, synchronous active-high reset
//   din        : asynchronous strip line
//   addr       : pixel index 1..NUM_LEDS of the current write
//   data       : pixel word {G,R,B}; first received bit in data[23]
//   wen        : one-cycle write strobe
//   frame_done : one-cycle pulse on a latch gap after received bits
//   pix_count  : pixels written in the last completed frame
//   frame_err  : one-cycle pulse when a frame ends with a partial pixel
//   overflow   : sticky until the next frame_done; more than NUM_LEDS pixels
module ws2812_rx
    import ws2812_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              din,
    output logic [ADDR_W-1:0] addr,
    output logic [WORD_W-1:0] data,
    output logic              wen,
    output logic              frame_done,
    output logic [ADDR_W-1:0] pix_count,
    output logic              frame_err,
    output logic              overflow
);

    localparam logic [CNT_W-1:0]  THRESH_W  = CNT_W'(BIT_THRESH);
    localparam logic [CNT_W-1:0]  MIN_W     = CNT_W'(MIN_HIGH);
    localparam logic [ADDR_W-1:0] LEDS_A    = ADDR_W'(NUM_LEDS);
    localparam logic [BCNT_W-1:0] LAST_BIT  = BCNT_W'(WORD_W - 1);

    logic             rise, fall, low_timeout, low_gap, high_timeout;
    logic [CNT_W-1:0] width;

    ws2812_pulse_meas u_meas (
        .clk          (clk),
        .reset        (reset),
        .din          (din),
        .rise         (rise),
        .fall         (fall),
        .width        (width),
        .low_timeout  (low_timeout),
        .low_gap      (low_gap),
        .high_timeout (high_timeout)
    );

    rx_state_t         state, state_n;
    logic [BCNT_W-1:0] bit_cnt, bit_cnt_n;
    logic [WORD_W-1:0] shift, shift_n, word;
    logic [ADDR_W-1:0] pix_idx, pix_idx_n;
    logic              active, active_n;
    logic [ADDR_W-1:0] addr_n, pix_count_n;
    logic [WORD_W-1:0] data_n;
    logic              wen_n, frame_done_n, frame_err_n, overflow_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= WAIT_IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            pix_idx    <= '0;
            active     <= 1'b0;
            addr       <= '0;
            data       <= '0;
            wen        <= 1'b0;
            frame_done <= 1'b0;
            pix_count  <= '0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            shift      <= shift_n;
            pix_idx    <= pix_idx_n;
            active     <= active_n;
            addr       <= addr_n;
            data       <= data_n;
            wen        <= wen_n;
            frame_done <= frame_done_n;
            pix_count  <= pix_count_n;
            frame_err  <= frame_err_n;
            overflow   <= overflow_n;
        end
    end

    assign word = {shift[WORD_W-2:0], (width >= THRESH_W)};

    always_comb begin
        state_n      = state;
        bit_cnt_n    = bit_cnt;
        shift_n      = shift;
        pix_idx_n    = pix_idx;
        active_n     = active;
        addr_n       = addr;
        data_n       = data;
        wen_n        = 1'b0;
        frame_done_n = 1'b0;
        pix_count_n  = pix_count;
        frame_err_n  = 1'b0;
        overflow_n   = overflow;

        case (state)
            WAIT_IDLE: begin
                if (low_timeout) begin
                    state_n = LOW;
                end
            end
            LOW: begin
                if (rise) begin
                    state_n = HIGH;
                end else if (low_gap) begin
                    // low_gap is a single-cycle pulse, so this runs once per gap
                    if (active) begin
                        frame_done_n = 1'b1;
                        pix_count_n  = pix_idx;
                        overflow_n   = 1'b0;
                        frame_err_n  = (bit_cnt != '0);
                    end
                    bit_cnt_n = '0;
                    shift_n   = '0;
                    pix_idx_n = '0;
                    active_n  = 1'b0;
                end
            end
            HIGH: begin
                if (fall) begin
                    state_n = LOW;
                    if (width >= MIN_W) begin
                        active_n = 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt_n = '0;
                            shift_n   = '0;
                            if (pix_idx < LEDS_A) begin
                                pix_idx_n = pix_idx + ADDR_W'(1);
                                addr_n    = pix_idx + ADDR_W'(1);
                                data_n    = word;
                                wen_n     = 1'b1;
                            end else begin
                                overflow_n = 1'b1;
                            end
                        end else begin
                            bit_cnt_n = bit_cnt + BCNT_W'(1);
                            shift_n   = word;
                        end
                    end
                end else if (high_timeout) begin
                    // Stuck-high line: abandon the frame and realign on a gap.
                    state_n     = WAIT_IDLE;
                    frame_err_n = 1'b1;
                    bit_cnt_n   = '0;
                    shift_n     = '0;
                    pix_idx_n   = '0;
                    active_n    = 1'b0;
                end
            end
            default: begin
                state_n = WAIT_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ws2812_rx.sv
module tb_ws2812_rx;

    logic        clk = 1'b0;
    logic        reset;
    logic        din;
    logic [5:0]  addr;
    logic [23:0] data;
    logic        wen;
    logic        frame_done;
    logic [5:0]  pix_count;
    logic        frame_err;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;
    int fe_cnt = 0;
    int exp_idx = 0;

    logic [29:0] sb[$];

    always #5 clk = ~clk;

    ws2812_rx dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .addr       (addr),
        .data       (data),
        .wen        (wen),
        .frame_done (frame_done),
        .pix_count  (pix_count),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // din changes 1 time unit after a rising edge, so a level held for n
    // calls of the clock is seen for exactly n cycles after synchronisation.
    task automatic hold(input logic lvl, input int n);
        din = lvl;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input bit fast);
        if (fast) begin
            hold(1'b1, b ? 31 : 6);
            hold(1'b0, 4);
        end else begin
            hold(1'b1, b ? 40 : 20);
            hold(1'b0, b ? 22 : 42);
        end
    endtask

    task automatic send_raw(input logic [23:0] w, input int nbits, input bit fast);
        for (int i = 23; i > 23 - nbits; i--) send_bit(w[i], fast);
    endtask

    task automatic expect_pixel(input logic [23:0] w);
        if (exp_idx < 60) begin
            exp_idx++;
            sb.push_back({6'(exp_idx), w});
        end
    endtask

    task automatic send_pixel(input logic [23:0] w, input bit fast);
        expect_pixel(w);
        send_raw(w, 24, fast);
    endtask

    task automatic end_frame(input string tag, input int d_fd, input int d_fe, input int pix);
        int fd0;
        int fe0;
        fd0 = fd_cnt;
        fe0 = fe_cnt;
        hold(1'b0, 2600);
        check({tag, "_frame_done"}, 32'(fd_cnt - fd0), 32'(d_fd));
        check({tag, "_frame_err"}, 32'(fe_cnt - fe0), 32'(d_fe));
        check({tag, "_pix_count"}, 32'(pix_count), 32'(pix));
        check({tag, "_overflow_clr"}, 32'(overflow), 32'd0);
        check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
        sb.delete();
        exp_idx = 0;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (wen) begin
                check("wen_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    logic [29:0] e;
                    e = sb.pop_front();
                    check("wen_addr", 32'(addr), 32'(e[29:24]));
                    check("wen_data", 32'(data), 32'(e[23:0]));
                end
            end
            if (frame_done) begin
                fd_cnt++;
                check("fd_excl_wen", 32'(wen), 32'd0);
            end
            if (frame_err) fe_cnt++;
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [23:0] glitch_word;
        reset = 1'b1;
        din   = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_data", 32'(data), 32'd0);
        check("rst_wen", 32'(wen), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_pix_count", 32'(pix_count), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        reset = 1'b0;

        // Single pixel at nominal timing.
        hold(1'b0, 2510);
        send_pixel(24'h00FF00, 1'b0);
        end_frame("one_pix", 1, 0, 1);

        // Full strip.
        for (int i = 1; i <= 60; i++) send_pixel(24'(i), 1'b1);
        hold(1'b0, 5);
        check("full_overflow", 32'(overflow), 32'd0);
        end_frame("full", 1, 0, 60);

        // One pixel too many.
        for (int i = 1; i <= 61; i++) send_pixel(24'(i + 100), 1'b1);
        hold(1'b0, 5);
        check("ovf_set", 32'(overflow), 32'd1);
        end_frame("ovf", 1, 0, 60);

        // Partial pixel then latch, then a good pixel.
        send_raw(24'hABC000, 12, 1'b0);
        end_frame("partial", 1, 1, 0);
        send_pixel(24'h123456, 1'b0);
        end_frame("after_partial", 1, 0, 1);

        // Glitches between bits; 29/30-cycle highs on the threshold.
        glitch_word = 24'hA5A5A5;
        expect_pixel(glitch_word);
        for (int i = 23; i >= 0; i--) begin
            int w;
            if (glitch_word[i]) w = (i % 3 == 0) ? 30 : 40;
            else                w = (i % 3 == 0) ? 29 : 20;
            hold(1'b1, w);
            hold(1'b0, 62 - w);
            hold(1'b1, 3);
            hold(1'b0, 10);
        end
        end_frame("glitch", 1, 0, 1);

        // Reset released in the middle of a pixel, stream keeps running.
        send_raw(24'hFFFFFF, 10, 1'b0);
        reset = 1'b1;
        hold(1'b1, 10);
        reset = 1'b0;
        hold(1'b1, 10);
        hold(1'b0, 30);
        send_raw(24'h3C3C3C, 14, 1'b0);
        send_raw(24'h777777, 24, 1'b0);
        end_frame("midrst", 0, 0, 0);
        send_pixel(24'hC0FFEE, 1'b0);
        end_frame("post_rst", 1, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
